// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the FIFO packet framer (write side) and its future read-side deframer.
// Contents: default widths, tag bit position and tag values, trailer ordering, FSM state enum.
package fifo_pkt_pkg;

    localparam int unsigned DEF_DW      = 15;
    localparam int unsigned DEF_MAX_LEN = 256;

    // FIFO word is {tag, word}; the tag sits just above the payload bits.
    localparam int unsigned TAG_BIT = DEF_DW;

    localparam logic TAG_PAYLOAD = 1'b0;
    localparam logic TAG_TRAILER = 1'b1;

    // Trailer words follow the payload in this order.
    localparam int unsigned TRAILER_WORDS   = 2;
    localparam int unsigned TRAILER_LEN_POS = 0;
    localparam int unsigned TRAILER_SUM_POS = 1;

    typedef enum logic [1:0] {
        PAYLOAD = 2'd0,
        LEN     = 2'd1,
        SUM     = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_pkt_if.sv
// Upstream payload stream plus FIFO write port bundled as one interface.
//   master: drives in_valid/in_data/in_last and fifo_full (upstream source + FIFO model)
//   slave : the framer; drives in_ready, wr_en, wr_data
interface fifo_pkt_if
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          wr_en;
    logic [DW:0]   wr_data;
    logic          fifo_full;

    modport master (
        output in_valid, in_data, in_last, fifo_full,
        input  in_ready, wr_en, wr_data
    );

    modport slave (
        input  in_valid, in_data, in_last, fifo_full,
        output in_ready, wr_en, wr_data
    );
endinterface

// File: rtl/fifo_wr_slot.sv
// Single-entry output hold register in front of the FIFO write port.
//   load/load_data : new word to present (only honoured when the slot frees)
//   fifo_full      : FIFO full flag; a presented word is held bit-stable while full
//   wr_en/wr_data  : registered FIFO write request and word
//   free           : slot drains or is empty this cycle (combinational)
module fifo_wr_slot #(
    parameter int unsigned W = 16
) (
    input  logic         wr_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         fifo_full,
    output logic         wr_en,
    output logic [W-1:0] wr_data,
    output logic         free
);

    assign free = !wr_en || !fifo_full;

    // Hold while stalled; otherwise take the new word or go idle.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
        end else if (free) begin
            wr_en <= load;
            if (load) begin
                wr_data <= load_data;
            end
        end
    end

endmodule

// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer: forwards payload words into the FIFO tagged 0, then closes each
// packet with a length word and an XOR checksum word, both tagged 1.
//   wr_clk, rst_n : clock, async active-low reset (shared with the FIFO)
//   bus           : upstream valid/ready stream and FIFO write port (slave modport)
//   pkt_cnt       : packets closed so far, wraps at 2^16
//   trunc_err     : one-cycle pulse when a packet is force-closed at MAX_LEN
//   busy          : packet in progress or a word still pending in the output slot
module fifo_pkt_writer
    import fifo_pkt_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned MAX_LEN = DEF_MAX_LEN
) (
    input  logic        wr_clk,
    input  logic        rst_n,
    fifo_pkt_if.slave   bus,
    output logic [15:0] pkt_cnt,
    output logic        trunc_err,
    output logic        busy
);

    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] csum;

    logic          free;
    logic          hs;
    logic          at_limit;
    logic          load_c;
    logic [DW:0]   load_data_c;

    // Upstream may only hand over a word while the slot can take it.
    assign bus.in_ready = rst_n && (state == PAYLOAD) && free;
    assign hs           = bus.in_valid && bus.in_ready;
    assign at_limit     = (cnt + CW'(1)) == CW'(MAX_LEN);

    assign busy = (state != PAYLOAD) || (cnt != '0) || bus.wr_en;

    // Select the word offered to the output slot.
    always_comb begin
        load_c      = 1'b0;
        load_data_c = '0;
        unique case (state)
            PAYLOAD: begin
                load_c      = hs;
                load_data_c = {TAG_PAYLOAD, bus.in_data};
            end
            LEN: begin
                load_c      = free;
                load_data_c = {TAG_TRAILER, DW'(cnt)};
            end
            SUM: begin
                load_c      = free;
                load_data_c = {TAG_TRAILER, csum};
            end
            default: begin
                load_c      = 1'b0;
                load_data_c = '0;
            end
        endcase
    end

    // Framing FSM with length/checksum accumulators and status outputs.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PAYLOAD;
            cnt       <= '0;
            csum      <= '0;
            pkt_cnt   <= '0;
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= 1'b0;
            unique case (state)
                PAYLOAD: begin
                    if (hs) begin
                        cnt  <= cnt + CW'(1);
                        csum <= csum ^ bus.in_data;
                        if (bus.in_last || at_limit) begin
                            state     <= LEN;
                            trunc_err <= !bus.in_last;
                        end
                    end
                end
                LEN: begin
                    if (free) begin
                        state <= SUM;
                    end
                end
                SUM: begin
                    if (free) begin
                        cnt     <= '0;
                        csum    <= '0;
                        pkt_cnt <= pkt_cnt + 16'd1;
                        state   <= PAYLOAD;
                    end
                end
                default: begin
                    state <= PAYLOAD;
                end
            endcase
        end
    end

    fifo_wr_slot #(
        .W (DW + 1)
    ) u_slot (
        .wr_clk    (wr_clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .load_data (load_data_c),
        .fifo_full (bus.fifo_full),
        .wr_en     (bus.wr_en),
        .wr_data   (bus.wr_data),
        .free      (free)
    );

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Self-checking bench for fifo_pkt_writer: one instance with MAX_LEN=256 and one with MAX_LEN=4.
// A transaction-level model builds the expected FIFO word stream; monitors capture actual writes.
module tb_fifo_pkt_writer;

    localparam int unsigned DW = 15;

    logic wr_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 wr_clk = ~wr_clk;

    fifo_pkt_if #(.DW(DW)) b0 ();
    fifo_pkt_if #(.DW(DW)) b4 ();

    logic [15:0] pkt0, pkt4;
    logic        te0, te4, busy0, busy4;

    fifo_pkt_writer #(.DW(DW), .MAX_LEN(256)) dut (
        .wr_clk (wr_clk), .rst_n (rst_n), .bus (b0),
        .pkt_cnt (pkt0), .trunc_err (te0), .busy (busy0)
    );

    fifo_pkt_writer #(.DW(DW), .MAX_LEN(4)) dut4 (
        .wr_clk (wr_clk), .rst_n (rst_n), .bus (b4),
        .pkt_cnt (pkt4), .trunc_err (te4), .busy (busy4)
    );

    int nvec = 0;
    int nmis = 0;

    int unsigned cyc = 0;
    always @(posedge wr_clk) cyc <= cyc + 1;

    // Monitors: a write lands at the next edge when wr_en && !fifo_full.
    logic [DW:0] obs0[$], obs4[$];
    int unsigned oc0[$], oc4[$];
    int unsigned tp0 = 0, tp4 = 0;
    always @(negedge wr_clk) begin
        if (b0.wr_en && !b0.fifo_full) begin
            obs0.push_back(b0.wr_data);
            oc0.push_back(cyc);
        end
        if (b4.wr_en && !b4.fifo_full) begin
            obs4.push_back(b4.wr_data);
            oc4.push_back(cyc);
        end
        if (te0) tp0 <= tp0 + 1;
        if (te4) tp4 <= tp4 + 1;
    end

    // Reference model state (index 0: MAX_LEN=256, index 1: MAX_LEN=4).
    logic [DW:0]   exp0[$], exp4[$];
    int unsigned   m_len[2]   = '{0, 0};
    logic [DW-1:0] m_csum[2]  = '{'0, '0};
    int unsigned   m_pkt[2]   = '{0, 0};
    int unsigned   m_trunc[2] = '{0, 0};
    int unsigned   rd0 = 0, rd4 = 0, tbase0 = 0, tbase4 = 0;
    bit            rnd_full = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        nvec++;
        assert (o === e) else begin
            nmis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    task automatic set_in(input int s, input logic v, input logic [DW-1:0] d, input logic l);
        if (s == 0) begin
            b0.in_valid = v; b0.in_data = d; b0.in_last = l;
        end else begin
            b4.in_valid = v; b4.in_data = d; b4.in_last = l;
        end
    endtask

    task automatic set_full(input int s, input logic f);
        if (s == 0) b0.fifo_full = f;
        else        b4.fifo_full = f;
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? b0.in_ready : b4.in_ready;
    endfunction

    // Packet rules: words pass through tagged 0; a packet closes on last or at the length limit
    // with {1,length} then {1,xor of words}.
    task automatic model(input int s, input logic [DW-1:0] d, input logic last);
        int unsigned lim;
        logic [DW:0] w[$];
        lim = (s == 0) ? 256 : 4;
        w.push_back({1'b0, d});
        m_len[s]++;
        m_csum[s] ^= d;
        if (last || m_len[s] == lim) begin
            w.push_back({1'b1, DW'(m_len[s])});
            w.push_back({1'b1, m_csum[s]});
            m_pkt[s]++;
            if (!last) m_trunc[s]++;
            m_len[s]  = 0;
            m_csum[s] = '0;
        end
        foreach (w[i]) begin
            if (s == 0) exp0.push_back(w[i]);
            else        exp4.push_back(w[i]);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send(input int s, input logic [DW-1:0] d, input logic last);
        bit r;
        bit ok;
        ok = 1'b0;
        set_in(s, 1'b1, d, last);
        for (int i = 0; i < 200; i++) begin
            @(negedge wr_clk);
            r = rdy(s);
            @(posedge wr_clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
            if (rnd_full) set_full(s, $urandom_range(0, 2) == 0);
        end
        set_in(s, 1'b0, '0, 1'b0);
        if (rnd_full) set_full(s, $urandom_range(0, 2) == 0);
        chk("send_accepted", 32'(ok), 32'd1);
        if (ok) model(s, d, last);
    endtask

    task automatic drain_check(input int s, input string tag, input bit consec);
        bit          idle;
        int unsigned rd, tp, tb;
        logic [DW:0] o[$];
        logic [DW:0] e[$];
        int unsigned c[$];
        idle = 1'b0;
        set_full(s, 1'b0);
        for (int i = 0; i < 300; i++) begin
            @(negedge wr_clk);
            if (!((s == 0) ? busy0 : busy4)) begin
                idle = 1'b1;
                break;
            end
        end
        if (s == 0) begin
            o = obs0; c = oc0; e = exp0; rd = rd0; tp = tp0; tb = tbase0;
        end else begin
            o = obs4; c = oc4; e = exp4; rd = rd4; tp = tp4; tb = tbase4;
        end
        chk({tag, "_idle"}, 32'(idle), 32'd1);
        chk({tag, "_count"}, 32'(o.size() - rd), 32'(e.size()));
        foreach (e[i]) begin
            if (rd + i < o.size()) begin
                chk({tag, "_word"}, 32'(o[rd + i]), 32'(e[i]));
                if (consec) chk({tag, "_cycle"}, c[rd + i] - c[rd], 32'(i));
            end
        end
        chk({tag, "_pkt_cnt"}, 32'((s == 0) ? pkt0 : pkt4), 32'(16'(m_pkt[s])));
        chk({tag, "_trunc_pulses"}, tp - tb, m_trunc[s]);
        m_trunc[s] = 0;
        if (s == 0) begin
            rd0 = o.size(); tbase0 = tp; exp0.delete();
        end else begin
            rd4 = o.size(); tbase4 = tp; exp4.delete();
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"},     32'(b0.wr_en),   32'd0);
        chk({tag, "_wr_data"},   32'(b0.wr_data), 32'd0);
        chk({tag, "_pkt_cnt"},   32'(pkt0),       32'd0);
        chk({tag, "_trunc_err"}, 32'(te0),        32'd0);
        chk({tag, "_busy"},      32'(busy0),      32'd0);
        chk({tag, "_in_ready"},  32'(b0.in_ready), 32'd0);
        chk({tag, "_in_ready4"}, 32'(b4.in_ready), 32'd0);
    endtask

    initial begin
        int unsigned len;
        set_in(0, 1'b0, '0, 1'b0);
        set_in(1, 1'b0, '0, 1'b0);
        set_full(0, 1'b0);
        set_full(1, 1'b0);

        // Reset values
        @(negedge wr_clk);
        chk_reset_outputs("reset");
        repeat (2) @(posedge wr_clk);
        #1 rst_n = 1'b1;
        @(negedge wr_clk);
        chk("post_reset_in_ready", 32'(b0.in_ready), 32'd1);
        @(posedge wr_clk);
        #1;

        // Basic packet: 1, 2, 4 -> 0x0001 0x0002 0x0004 0x8003 0x8007
        send(0, 15'h0001, 1'b0);
        send(0, 15'h0002, 1'b0);
        send(0, 15'h0004, 1'b1);
        drain_check(0, "basic", 1'b1);

        // Back-to-back single-word packets
        send(0, 15'h0005, 1'b1);
        send(0, 15'h000A, 1'b1);
        drain_check(0, "b2b", 1'b1);

        // Backpressure: hold 0x0002 for 5 full cycles with a word waiting upstream
        send(0, 15'h0001, 1'b0);
        send(0, 15'h0002, 1'b0);
        set_full(0, 1'b1);
        set_in(0, 1'b1, 15'h0004, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            chk("bp_hold_data", 32'(b0.wr_data), 32'h0002);
            chk("bp_hold_wr_en", 32'(b0.wr_en), 32'd1);
            chk("bp_in_ready", 32'(b0.in_ready), 32'd0);
        end
        @(posedge wr_clk);
        #1 set_full(0, 1'b0);
        send(0, 15'h0004, 1'b1);
        drain_check(0, "bp", 1'b0);

        // Truncation at MAX_LEN=4, then remaining words form a new packet
        for (int d = 1; d <= 6; d++) begin
            send(1, DW'(d), 1'b0);
            if (d == 4) begin
                @(negedge wr_clk);
                chk("trunc_pulse_timing", 32'(te4), 32'd1);
                @(posedge wr_clk);
                #1;
            end
        end
        send(1, 15'h0007, 1'b1);
        drain_check(1, "trunc", 1'b1);

        // Reset mid-packet: discard partial packet, no trailer
        send(0, 15'h0009, 1'b0);
        send(0, 15'h0006, 1'b0);
        rst_n = 1'b0;
        @(negedge wr_clk);
        chk_reset_outputs("midrst");
        m_len     = '{0, 0};
        m_csum    = '{'0, '0};
        m_pkt     = '{0, 0};
        exp0.delete();
        rd0 = obs0.size();
        @(posedge wr_clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge wr_clk);
        chk("midrst_no_trailer", 32'(obs0.size()), 32'(rd0));
        @(posedge wr_clk);
        #1;
        send(0, 15'h0003, 1'b1);
        drain_check(0, "post_rst", 1'b1);

        // Randomized packets, gaps and FIFO backpressure on both instances
        rnd_full = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 20; p++) begin
                len = $urandom_range(1, (s == 0) ? 6 : 9);
                for (int w = 0; w < int'(len); w++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge wr_clk);
                        #1 set_full(s, $urandom_range(0, 2) == 0);
                    end
                    send(s, DW'($urandom), w == int'(len) - 1);
                end
            end
            drain_check(s, (s == 0) ? "rand256" : "rand4", 1'b0);
        end
        rnd_full = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_writer.md
# fifo_pkt_writer

Write-side packet framer in the `wr_clk` domain that feeds the async FIFO's write port. It accepts a valid/ready payload stream with an end-of-packet marker and writes each payload word into the FIFO. Each packet is closed with two tagged trailer words: a length word and an XOR-checksum word. It obeys the FIFO's write rule (a write is taken when `wr_en && !fifo_full`) and never drops or alters a word under backpressure.

## Interface
- `DW`, 15, payload word width; FIFO `WIDTH` must equal `DW+1`.
- `MAX_LEN`, 256, maximum payload words per packet; `$clog2(MAX_LEN+1) <= DW`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_clk`  in  1  clock; all logic is in this domain.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  upstream word accepted when `in_valid && in_ready`.
- `in_data`  in  DW  payload word.
- `in_last`  in  1  final word of the packet.
- `wr_en`  out  1  FIFO write request, registered.
- `wr_data`  out  DW+1  `{tag, word}`; tag=0 for payload, tag=1 for trailer; registered.
- `fifo_full`  in  1  FIFO full flag.
- `pkt_cnt`  out  16  completed packets (SUM word accepted), wraps at 2^16.
- `trunc_err`  out  1  one-cycle pulse when a packet is force-closed at `MAX_LEN`.
- `busy`  out  1  high while a packet is partially sent or an output word is pending.

## Operation
- Single output slot (`wr_en`/`wr_data`). Slot frees this cycle when `!wr_en || !fifo_full`.
- While `wr_en && fifo_full`, `wr_en` and `wr_data` are held bit-stable.
- FSM states: PAYLOAD, LEN, SUM. Reset state is PAYLOAD.
- PAYLOAD:
  - `in_ready = slot frees`.
  - On handshake: slot <= `{0,in_data}`, `cnt++`, `csum ^= in_data`.
  - If `in_last` or `cnt+1 == MAX_LEN`, go to LEN. Pulse `trunc_err` if `in_last` is 0.
- LEN:
  - `in_ready=0`.
  - When the slot frees: slot <= `{1, zero-extended cnt}`, go to SUM.
- SUM:
  - `in_ready=0`.
  - When the slot frees: slot <= `{1, csum}`, clear `cnt` and `csum`, `pkt_cnt++`, go to PAYLOAD.
- If no new word is loaded when the slot frees, `wr_en` goes to 0.
- Zero-length packets cannot occur.
- After truncation, subsequent upstream words start a new packet.
- `busy = (state!=PAYLOAD) || cnt!=0 || wr_en`.
- Reset mid-packet: the partial packet and the pending slot word are discarded, no trailer is emitted, and `pkt_cnt` returns to 0. The FIFO shares `rst_n`.

## Timing
- Reset values: `wr_en=0`, `wr_data=0`, `pkt_cnt=0`, `trunc_err=0`, `busy=0`. `in_ready` is forced 0 while `rst_n` is low.
- `in_ready` is combinational from `fifo_full`, `wr_en` and state.
- Latency: a word accepted at edge N is presented with `wr_en=1` in cycle N+1.
- With no backpressure, LEN is presented in N+2 and SUM in N+3 after the last word at N. The first word of the next packet is accepted at N+3.
- Sustained throughput: an L-word packet occupies L+2 consecutive FIFO write cycles.
- `fifo_full` rising while `wr_en=1`: the word stalls, with no duplicate and no loss.
- `trunc_err` is asserted in the cycle after the truncating handshake.

## Structure
- Package `fifo_pkt_pkg` holds:
  - `TAG_BIT = DW`.
  - The FSM state enum (PAYLOAD, LEN, SUM).
  - Trailer ordering constants, shared with the future read-side deframer.
- Sub-module `fifo_wr_slot`: the single-entry hold register. Its inputs are `load`, `load_data` and `fifo_full`. Its outputs are `wr_en`, `wr_data` and `free`. The FSM and counters stay in the top module.

## Test plan
- **Basic packet:** payload `0x0001`, `0x0002`, `0x0004` (last on third), `fifo_full=0`.
  - FIFO receives `0x0001`, `0x0002`, `0x0004`, `0x8003`, `0x8007` in consecutive cycles.
  - `pkt_cnt=1`.
- **Back-to-back:** two 1-word packets `0x0005`, `0x000A`, both with last.
  - Six consecutive writes: `0x0005`, `0x8001`, `0x8005`, `0x000A`, `0x8001`, `0x800A`.
  - `pkt_cnt=2`.
- **Backpressure:** `fifo_full=1` for 5 cycles while `wr_data=0x0002`.
  - `wr_data` is held at `0x0002` and `in_ready=0` for those cycles.
  - After release, the full packet matches the no-stall sequence.
- **Truncation:** `MAX_LEN=4`, 6 words `0x0001`..`0x0006`, no `in_last`, then last on a 7th word `0x0007`.
  - FIFO receives words 1-4, `0x8004`, `0x8004`; `trunc_err` pulses once.
  - Then words 5-7, `0x8003`, `0x8004`.
- **Reset mid-packet:** `rst_n` low after 2 payload words.
  - Outputs go to their reset values and no trailer is emitted.
  - A new 1-word packet `0x0003` after reset yields `0x0003`, `0x8001`, `0x8003`, with `pkt_cnt=1`.
